friet_xaon_sliced: RTL and testbench

FRIET_XAON_SLICED -- requirements
Module: friet_xaon_sliced

---
 rtl/friet_xaon_sliced.sv | 108 ++++++++++
 tb/tb_friet_xaon_sliced.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/friet_xaon_sliced.sv
// rtl/friet_xaon_sliced.sv - slice-serial XAON/XOON: dout = (rotl(a) AND/OR rotl(b)) XOR c
module friet_xaon_sliced #(
  parameter int WIDTH = 128,
  parameter int SLICE = 32,
  parameter int ROT_A = 0,
  parameter int ROT_B = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic [WIDTH-1:0] din_c,
  input  logic             din_mode,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout_o,
  output logic             busy
);

  // WIDTH must be a multiple of SLICE; N slices are produced one per cycle.
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int RA = ROT_A % WIDTH;
  localparam int RB = ROT_B % WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rc;
  logic             mode;
  logic             last;
  logic [WIDTH-1:0] full;
  logic [SLICE-1:0] sl;
  int               slice_base;

  // Rotation by zero is special-cased so no shift by WIDTH is ever formed.
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input int r);
    if (r == 0) return x;
    return (x << r) | (x >> (WIDTH - r));
  endfunction

  // Handshake and status flags are pure decodes of the state register.
  assign din_ready  = (state == IDLE);
  assign dout_valid = (state == DONE);
  assign busy       = (state != IDLE);
  assign last       = (cnt == CW'(N - 1));

  // Full-width bitwise result; each slice is just a window of it, so slicing adds no dependency.
  always_comb begin
    full       = (mode ? (ra | rb) : (ra & rb)) ^ rc;
    slice_base = int'(cnt) * SLICE;
    sl         = full[slice_base +: SLICE];
  end

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (din_valid)  state_nxt = RUN;
      RUN:     if (last)       state_nxt = DONE;
      DONE:    if (dout_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Operand capture on acceptance, then one result slice written per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      ra     <= '0;
      rb     <= '0;
      rc     <= '0;
      mode   <= 1'b0;
      dout_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (din_valid) begin
            ra     <= rotl(din_a, RA);
            rb     <= rotl(din_b, RB);
            rc     <= din_c;
            mode   <= din_mode;
            dout_o <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          dout_o[slice_base +: SLICE] <= sl;
          cnt <= last ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_friet_xaon_sliced.sv
// tb/tb_friet_xaon_sliced.sv - directed and randomized checks of friet_xaon_sliced (16/4, ROT_A=1)
module tb_friet_xaon_sliced;

  logic        clk;
  logic        rst;
  logic        din_valid;
  logic        din_ready;
  logic [15:0] din_a;
  logic [15:0] din_b;
  logic [15:0] din_c;
  logic        din_mode;
  logic        dout_valid;
  logic        dout_ready;
  logic [15:0] dout_o;
  logic        busy;

  int checks;
  int errors;

  friet_xaon_sliced #(.WIDTH(16), .SLICE(4), .ROT_A(1), .ROT_B(0)) dut (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din_ready(din_ready),
    .din_a(din_a), .din_b(din_b), .din_c(din_c), .din_mode(din_mode),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_o(dout_o),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset clears everything and leaves the block ready.
  task automatic test_reset;
    rst = 1'b1; din_valid = 1'b0; dout_ready = 1'b0;
    din_a = '0; din_b = '0; din_c = '0; din_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({din_ready, dout_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: got ready/valid/busy=%b required 100", {din_ready, dout_valid, busy});
    end
    checks++;
    if (dout_o !== 16'h0000) begin
      errors++;
      $display("FAIL reset_dout: got %h required 0000", dout_o);
    end
  endtask

  // Mode 0 (XAON): result 0x1237 after exactly 4 RUN cycles, then back to IDLE.
  task automatic test_mode0;
    din_a = 16'h8001; din_b = 16'h00FF; din_c = 16'h1234; din_mode = 1'b0;
    dout_ready = 1'b1; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    checks++;
    if ({din_ready, dout_valid, busy} !== 3'b001) begin
      errors++;
      $display("FAIL m0_run_flags: got ready/valid/busy=%b required 001", {din_ready, dout_valid, busy});
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (dout_valid !== (k == 4)) begin
        errors++;
        $display("FAIL m0_valid_timing: cycle %0d got valid=%b required %b", k, dout_valid, (k == 4));
      end
    end
    checks++;
    if (dout_o !== 16'h1237) begin
      errors++;
      $display("FAIL m0_result: got %h required 1237", dout_o);
    end
    @(negedge clk);
    checks++;
    if ({din_ready, dout_valid, busy} !== 3'b100 || dout_o !== 16'h1237) begin
      errors++;
      $display("FAIL m0_after_hs: got ready/valid/busy=%b dout=%h required 100 1237",
               {din_ready, dout_valid, busy}, dout_o);
    end
  endtask

  // Mode 1 (XOON): unwritten slices read 0, partial results visible as slices land.
  task automatic test_mode1;
    logic [15:0] exp_k [1:4];
    exp_k[1] = 16'h000B; exp_k[2] = 16'h00CB; exp_k[3] = 16'h02CB; exp_k[4] = 16'h12CB;
    din_a = 16'h8001; din_b = 16'h00FF; din_c = 16'h1234; din_mode = 1'b1;
    dout_ready = 1'b1; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    checks++;
    if (dout_o !== 16'h0000) begin
      errors++;
      $display("FAIL m1_cleared: got %h required 0000", dout_o);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (dout_o !== exp_k[k]) begin
        errors++;
        $display("FAIL m1_partial: after slice %0d got %h required %h", k - 1, dout_o, exp_k[k]);
      end
    end
    checks++;
    if (dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL m1_valid: got %b required 1", dout_valid);
    end
    @(negedge clk);
  endtask

  // Held result under backpressure; din_valid pulses in DONE are ignored.
  task automatic test_backpressure;
    din_a = 16'h8001; din_b = 16'h00FF; din_c = 16'h1234; din_mode = 1'b0;
    dout_ready = 1'b0; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({din_ready, dout_valid, busy} !== 3'b011 || dout_o !== 16'h1237) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got ready/valid/busy=%b dout=%h required 011 1237",
                 i, {din_ready, dout_valid, busy}, dout_o);
      end
      if (i == 3) begin
        din_valid = 1'b1; din_a = 16'hFFFF; din_b = 16'hFFFF; din_c = 16'h0000; din_mode = 1'b1;
      end else begin
        din_valid = 1'b0;
      end
      @(negedge clk);
    end
    dout_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({din_ready, dout_valid, busy} !== 3'b100 || dout_o !== 16'h1237) begin
      errors++;
      $display("FAIL bp_release: got ready/valid/busy=%b dout=%h required 100 1237",
               {din_ready, dout_valid, busy}, dout_o);
    end
  endtask

  // Reset on the second RUN cycle aborts; the first cycle after reset accepts again.
  task automatic test_reset_run;
    int  waited;
    din_a = 16'h8001; din_b = 16'h00FF; din_c = 16'h1234; din_mode = 1'b0;
    dout_ready = 1'b1; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({din_ready, dout_valid, busy} !== 3'b100 || dout_o !== 16'h0000) begin
      errors++;
      $display("FAIL rr_abort: got ready/valid/busy=%b dout=%h required 100 0000",
               {din_ready, dout_valid, busy}, dout_o);
    end
    rst = 1'b0;
    din_a = 16'h0000; din_b = 16'h0000; din_c = 16'hFFFF; din_mode = 1'b0; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rr_accept_first: got busy=%b required 1", busy);
    end
    waited = 0;
    while (dout_valid !== 1'b1 && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited != 4 || dout_o !== 16'hFFFF) begin
      errors++;
      $display("FAIL rr_result: got dout=%h after %0d cycles required FFFF after 4", dout_o, waited);
    end
    @(negedge clk);
  endtask

  // din_valid held high: second triple accepted right after the first handshake, period N+2.
  task automatic test_back_to_back;
    int gap;
    din_a = 16'h8001; din_b = 16'h00FF; din_c = 16'h1234; din_mode = 1'b0;
    dout_ready = 1'b1; din_valid = 1'b1;
    @(negedge clk);
    din_a = 16'h4000; din_b = 16'h0F0F; din_c = 16'hA5A5; din_mode = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (dout_valid !== 1'b1 || dout_o !== 16'h1237) begin
      errors++;
      $display("FAIL b2b_first: got valid=%b dout=%h required 1 1237", dout_valid, dout_o);
    end
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (dout_valid !== 1'b1 && gap < 20);
    din_valid = 1'b0;
    // rotl(0x4000,1)=0x8000; 0x8000|0x0F0F=0x8F0F; ^0xA5A5 = 0x2AAA
    checks++;
    if (gap != 6 || dout_o !== 16'h2AAA) begin
      errors++;
      $display("FAIL b2b_second: got dout=%h gap=%0d required 2AAA gap=6", dout_o, gap);
    end
    @(negedge clk);
  endtask

  // Random triples with random input gaps and output stalls against the full-width formula.
  task automatic test_random;
    logic [15:0] a, b, c, ra, expv;
    logic        m, seen, hs;
    int          w;
    for (int it = 0; it < 200; it++) begin
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); m = 1'($urandom_range(0, 1));
      ra = {a[14:0], a[15]};
      expv = (m ? (ra | b) : (ra & b)) ^ c;
      dout_ready = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      w = 0;
      while (din_ready !== 1'b1 && w < 10) begin
        @(negedge clk);
        w++;
      end
      din_a = a; din_b = b; din_c = c; din_mode = m; din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      seen = 1'b0; hs = 1'b0;
      for (int k = 0; k < 40 && !hs; k++) begin
        dout_ready = 1'($urandom_range(0, 1));
        if (dout_valid === 1'b1 && !seen) begin
          seen = 1'b1;
          checks++;
          if (dout_o !== expv) begin
            errors++;
            $display("FAIL rand_result: iter %0d a=%h b=%h c=%h m=%b got %h required %h",
                     it, a, b, c, m, dout_o, expv);
          end
        end
        if (dout_valid === 1'b1 && dout_ready === 1'b1) hs = 1'b1;
        @(negedge clk);
      end
      if (!hs) begin
        checks++;
        errors++;
        $display("FAIL rand_timeout: iter %0d got no output handshake required one within 40 cycles", it);
      end
      dout_ready = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mode0();
    test_mode1();
    test_backpressure();
    test_reset_run();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
